pipeline_ctrl: RTL

//  Control end of the fetch-stage interface: drives op_pc_write, op_branch, branch_address and op_cc_write into fetch.

---
 rtl/pipeline_ctrl_pkg.sv | 62 ++++++
 rtl/pipeline_ctrl_if.sv | 33 +++
 rtl/pipeline_ctrl_down_counter.sv | 33 +++
 rtl/pipeline_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared state encodings, output struct and decode for pipeline_ctrl
package pipeline_ctrl_pkg;

    localparam int ADDR_WIDTH_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_STALL    = 3'd1,
        ST_REDIRECT = 3'd2,
        ST_FLUSH    = 3'd3,
        ST_HALT     = 3'd4
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic branch;
        logic cc_write;
        logic stall_if_id;
        logic flush_if_id;
        logic flush_id_ex;
        logic halted;
    } ctrl_out_t;

    // Moore output decode: every control output depends only on the state.
    function automatic ctrl_out_t decode_state(input state_e st);
        ctrl_out_t o;
        o = '0;
        case (st)
            ST_RUN: begin
                o.pc_write = 1'b1;
                o.cc_write = 1'b1;
            end
            ST_STALL: begin
                o.stall_if_id = 1'b1;
                o.flush_id_ex = 1'b1;
                o.cc_write    = 1'b1;
            end
            ST_REDIRECT: begin
                o.pc_write    = 1'b1;
                o.branch      = 1'b1;
                o.flush_if_id = 1'b1;
                o.flush_id_ex = 1'b1;
                o.cc_write    = 1'b1;
            end
            ST_FLUSH: begin
                o.pc_write    = 1'b1;
                o.flush_if_id = 1'b1;
                o.flush_id_ex = 1'b1;
                o.cc_write    = 1'b1;
            end
            ST_HALT: begin
                o.halted = 1'b1;
            end
            default: begin
                o.pc_write = 1'b1;
                o.cc_write = 1'b1;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - request inputs and fetch-side control outputs of pipeline_ctrl
interface pipeline_ctrl_if #(
    parameter int ADDR_WIDTH = 16
) ();
    logic                  branch_taken;
    logic [ADDR_WIDTH-1:0] branch_target;
    logic                  load_use_hazard;
    logic                  halt_req;
    logic                  resume;
    logic                  op_pc_write;
    logic                  op_branch;
    logic [ADDR_WIDTH-1:0] branch_address;
    logic                  op_cc_write;
    logic                  stall_if_id;
    logic                  flush_if_id;
    logic                  flush_id_ex;
    logic                  halted;
    logic [ADDR_WIDTH-1:0] redirect_count;

    // Controller side: consumes requests, drives fetch/pipeline controls.
    modport master (
        input  branch_taken, branch_target, load_use_hazard, halt_req, resume,
        output op_pc_write, op_branch, branch_address, op_cc_write,
               stall_if_id, flush_if_id, flush_id_ex, halted, redirect_count
    );

    // Pipeline side: raises requests, observes controls.
    modport slave (
        output branch_taken, branch_target, load_use_hazard, halt_req, resume,
        input  op_pc_write, op_branch, branch_address, op_cc_write,
               stall_if_id, flush_if_id, flush_id_ex, halted, redirect_count
    );
endinterface

// File: rtl/pipeline_ctrl_down_counter.sv
// rtl/pipeline_ctrl_down_counter.sv - 4-bit loadable down counter with zero flag
module down_counter (
    input  logic       clock,
    input  logic       reset,
    input  logic       load_i,
    input  logic [3:0] load_value_i,
    input  logic       dec_i,
    output logic       zero_o
);
    logic [3:0] count_q;
    logic [3:0] count_d;

    // Load has priority; decrement saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (dec_i && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == 4'd0);
endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/redirect/flush/halt sequencer driving the fetch stage
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEFAULT,
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic          clock,
    input  logic          reset,
    pipeline_ctrl_if.master bus
);
    // Counter holds "remaining cycles after this one", hence the minus one.
    localparam logic [3:0] STALL_LOAD = 4'(STALL_CYCLES - 1);
    localparam logic [3:0] FLUSH_LOAD = 4'((FLUSH_CYCLES > 0) ? (FLUSH_CYCLES - 1) : 0);
    localparam bit         HAS_FLUSH  = (FLUSH_CYCLES > 0);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] rcount_q, rcount_d;
    ctrl_out_t             out_q;
    logic                  cnt_load;
    logic [3:0]            cnt_value;
    logic                  cnt_dec;
    logic                  cnt_zero;

    down_counter u_counter (
        .clock        (clock),
        .reset        (reset),
        .load_i       (cnt_load),
        .load_value_i (cnt_value),
        .dec_i        (cnt_dec),
        .zero_o       (cnt_zero)
    );

    // Next-state, redirect target and counter control in request-priority order.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rcount_d  = rcount_q;
        cnt_load  = 1'b0;
        cnt_value = 4'd0;
        cnt_dec   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.halt_req) begin
                    state_d = ST_HALT;
                end else if (bus.branch_taken) begin
                    state_d = ST_REDIRECT;
                    addr_d  = bus.branch_target;
                end else if (bus.load_use_hazard) begin
                    state_d   = ST_STALL;
                    cnt_load  = 1'b1;
                    cnt_value = STALL_LOAD;
                end
            end
            ST_STALL: begin
                if (bus.halt_req) begin
                    state_d = ST_HALT;
                end else if (bus.branch_taken) begin
                    state_d = ST_REDIRECT;
                    addr_d  = bus.branch_target;
                end else if (cnt_zero) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_REDIRECT: begin
                rcount_d = rcount_q + ADDR_WIDTH'(1);
                if (bus.halt_req) begin
                    state_d = ST_HALT;
                end else if (!HAS_FLUSH) begin
                    state_d = ST_RUN;
                end else begin
                    state_d   = ST_FLUSH;
                    cnt_load  = 1'b1;
                    cnt_value = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                // Branch/hazard requests here come from squashed instructions.
                if (bus.halt_req) begin
                    state_d = ST_HALT;
                end else if (cnt_zero) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_HALT: begin
                if (bus.resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State, target, redirect count and registered Moore outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            addr_q   <= '0;
            rcount_q <= '0;
            out_q    <= decode_state(ST_RUN);
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rcount_q <= rcount_d;
            out_q    <= decode_state(state_d);
        end
    end

    assign bus.op_pc_write    = out_q.pc_write;
    assign bus.op_branch      = out_q.branch;
    assign bus.op_cc_write    = out_q.cc_write;
    assign bus.stall_if_id    = out_q.stall_if_id;
    assign bus.flush_if_id    = out_q.flush_if_id;
    assign bus.flush_id_ex    = out_q.flush_id_ex;
    assign bus.halted         = out_q.halted;
    assign bus.branch_address = addr_q;
    assign bus.redirect_count = rcount_q;
endmodule
